// File: rtl/ahb3lite_mem_responder.sv
// ahb3lite_mem_responder
//   AHB3-Lite responder backed by a word-organised register memory. Used as
//   the far end of the DMA master ports and as a bench memory model.
//   Programmable wait states, byte/half/word writes, and two-cycle ERROR
//   responses for illegal accesses (bad size, misaligned, out of window).
//
//   Optional build macro: AHB3LITE_MEM_RAND_WAIT_EN
//     When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//     adds 0..3 extra wait cycles to every legal beat.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   HSEL, HADDR, HWRITE   address-phase select, byte address, direction
//   HSIZE, HBURST, HPROT  size (0 byte, 1 half, 2 word); burst/prot ignored
//   HTRANS, HREADY        transfer type, bus ready (previous beat complete)
//   HWDATA                write data (data phase)
//   HRDATA                registered read data, holds outside read phases
//   HREADYOUT, HRESP      responder ready, 0 = OKAY / 1 = ERROR
module ahb3lite_mem_responder #(
    parameter int          MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          CW        = 5;   // holds WAIT_STATES + 3
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hrdata_q, hrdata_d;

    logic [31:0]     mem [MEM_WORDS];

    // HBURST/HPROT are ignored and HTRANS[0] only separates IDLE from BUSY
    // or NONSEQ from SEQ, which this responder treats identically.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    function automatic logic [AW-1:0] widx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'd0:    return 4'b0001 << a;
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic        accept;
    logic        misalign;
    logic        in_range;
    logic        illegal;
    logic [31:0] off;

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign off      = HADDR - BASE_ADDR;
    assign in_range = (HADDR >= BASE_ADDR) && (off < MEM_BYTES);
    assign misalign = ((HSIZE == 3'd1) && HADDR[0]) ||
                      ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign illegal  = (HSIZE > 3'd2) || misalign || !in_range;

    // ------------------------------------------------------------------
    // Per-beat wait count
    // ------------------------------------------------------------------
    logic [CW-1:0] wait_cnt;

`ifdef AHB3LITE_MEM_RAND_WAIT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign wait_cnt = CW'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
`else
    assign wait_cnt = CW'(WAIT_STATES);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            S_ERR1: state_d = S_ERR2;
            // IDLE, DATA and ERR2 all present HREADYOUT = 1, so they share the
            // accept rules; this is what gives back-to-back pipelined beats.
            default: begin
                if (accept) begin
                    addr_d  = HADDR;
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (wait_cnt != '0) begin
                        state_d = S_WAIT;
                        cnt_d   = wait_cnt;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write port: commits at the end of a write data phase
    // ------------------------------------------------------------------
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;

    assign wr_en  = (state_q == S_DATA) && write_q;
    assign wr_idx = widx(addr_q);
    assign wr_be  = lanes(size_q, addr_q[1:0]);

    // ------------------------------------------------------------------
    // Read data register. Loaded on the edge that enters a read data phase.
    // A zero-wait read right behind a write to the same word enters its data
    // phase on the same edge the write commits, so the write lanes are
    // forwarded into the loaded value.
    // ------------------------------------------------------------------
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    assign rd_idx = widx(addr_d);

    always_comb begin
        rd_word = mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_en && (wr_idx == rd_idx) && wr_be[b])
                rd_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
        hrdata_d = hrdata_q;
        if ((state_d == S_DATA) && !write_d)
            hrdata_d = rd_word;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            cnt_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Memory is not reset; a write pending when reset arrives is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = hrdata_q;

endmodule
